decoder_nx_seq: RTL and testbench
=================================

Name: decoder_nx_seq

Overview:
Parametrised, registered binary-to-one-hot decoder for 2^SEL_W outputs, with a valid/ready input handshake. The block has two modes. Direct mode latches a single select code and holds the one-hot output. Scan mode auto-steps through the outputs with a programmable dwell time. It drives output enables and strobes for LED/digit banks, demux steering, and channel select in the FPGA designs.

Parameters:
SEL_W, 3, select code width; output count OUT_W = 2**SEL_W (derived, not overridable)
DWELL_W, 8, width of the dwell count used in scan mode

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  command valid
in_ready  output  1  block can accept a command this cycle
mode  input  1  0 = direct, 1 = scan; sampled on accept
sel  input  SEL_W  select code (direct) or start index (scan); sampled on accept
dwell  input  DWELL_W  scan dwell; each index is held for dwell+1 cycles; sampled on accept
stop  input  1  abort scan or hold; returns block to IDLE
y  output  OUT_W  registered one-hot decode output
y_valid  output  1  y carries a live decode
active_idx  output  SEL_W  index currently asserted on y

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, y=0, y_valid=0, active_idx=0, dwell counter=0. in_ready reads 1 from the cycle after reset. Reset mid-scan or mid-hold aborts immediately and has priority over all inputs.
- Accept: a command is accepted when in_valid && in_ready at a clk edge.
- Latency: 1 cycle from accept to y / y_valid / active_idx update. All outputs are registered.
- States: IDLE, HOLD, SCAN.
- IDLE:
  - in_ready=1.
  - Accept with mode=0 -> HOLD, with y=1<<sel, active_idx=sel, y_valid=1.
  - Accept with mode=1 -> SCAN, with y=1<<sel, active_idx=sel, y_valid=1, dwell counter=dwell.
- HOLD:
  - in_ready=1; y is held indefinitely.
  - A new accept re-decodes on the next cycle; no gap cycle, y never passes through 0.
  - An accept with mode=1 enters SCAN as from IDLE.
- SCAN:
  - in_ready=0.
  - Each cycle: if counter != 0, decrement. If counter == 0, advance active_idx by 1, wrapping OUT_W-1 -> 0. Then y=1<<new idx and the counter reloads from the stored dwell.
  - dwell=0 means the output advances every cycle.
  - The scan runs until stop or reset.
- stop=1 in HOLD or SCAN: next cycle state=IDLE, y=0, y_valid=0; active_idx retains its last value.
- Simultaneous stop and accept (HOLD only): stop wins and the command is dropped. stop in IDLE has no effect.
- Invariant: y is always exactly one-hot when y_valid=1, and all-zero when y_valid=0 (polarity per the optional feature).
- Width rule: the dwell counter is DWELL_W bits, unsigned, with no overflow possible. Index arithmetic is modulo OUT_W.

Optional Feature:
ACTIVE_LOW_OUT_EN
- Defined: y is driven active-low, i.e. the selected bit is 0 and all others are 1. Idle, reset, and stop values are all-ones. The output is the bitwise inverse of the default encoding; timing and states are unchanged. This form suits NAND-style decoder targets and common-anode LED banks.
- Undefined (default): y is active-high one-hot and idles at 0.

Test Plan:
- Reset: assert rst for 2 cycles, then release -> y=0, y_valid=0, active_idx=0, in_ready=1 on the first cycle after release.
- Direct decode (SEL_W=3): accept mode=0, sel=5 -> next cycle y=8'b0010_0000, y_valid=1. Then accept sel=2 -> y=8'b0000_0100 the following cycle, with no zero cycle in between.
- Scan wrap: accept mode=1, sel=6, dwell=2.
  - y holds 1<<6 for 3 cycles, then 1<<7 for 3 cycles, then 1<<0.
  - active_idx sequence is 6,6,6,7,7,7,0.
  - in_ready=0 throughout.
- Scan dwell=0: start sel=0 -> active_idx increments every cycle, 0..7 then 0.
- Stop/priority: during SCAN assert stop -> next cycle y=0, y_valid=0, in_ready=1. In HOLD, assert stop together with in_valid (sel=3) -> command dropped, y=0. Assert rst mid-scan -> all outputs take their reset values next cycle.
- With ACTIVE_LOW_OUT_EN: accept mode=0, sel=1 -> y=8'b1111_1101; reset value is y=8'hFF.

Source files
------------

// File: rtl/decoder_nx_seq.sv
//==============================================================================
// Module   : decoder_nx_seq
// Brief    : Registered binary-to-one-hot decoder with a valid/ready command
//            port. Direct mode latches one select code and holds it. Scan mode
//            steps through all outputs, holding each for dwell+1 cycles.
// Options  : `define ACTIVE_LOW_OUT_EN -> y is driven active-low (selected bit
//            0, idle all-ones); timing and states are unchanged.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module decoder_nx_seq #(
   parameter  int SEL_W   = 3,
   parameter  int DWELL_W = 8,
   localparam int OUT_W   = 2**SEL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               stop,
   output logic [OUT_W-1:0]   y,
   output logic               y_valid,
   output logic [SEL_W-1:0]   active_idx
);

   // XOR mask applied to the active-high one-hot code before it is registered
`ifdef ACTIVE_LOW_OUT_EN
   localparam logic [OUT_W-1:0] C_POL_MASK = {OUT_W{1'b1}};
`else
   localparam logic [OUT_W-1:0] C_POL_MASK = {OUT_W{1'b0}};
`endif
   localparam logic [OUT_W-1:0] C_ONE = {{(OUT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_SCAN = 2'd2
   } state_t;

   state_t             r_state,  w_state_n;
   logic [OUT_W-1:0]   r_y,      w_y_n;
   logic               r_valid,  w_valid_n;
   logic [SEL_W-1:0]   r_idx,    w_idx_n;
   logic [DWELL_W-1:0] r_cnt,    w_cnt_n;
   logic [DWELL_W-1:0] r_dwell,  w_dwell_n;
   logic               w_accept;
   logic [SEL_W-1:0]   w_idx_inc;

   // Commands are only taken outside SCAN; scan runs until stop or reset
   assign in_ready   = (r_state != S_SCAN);
   assign w_accept   = in_valid && in_ready;
   assign w_idx_inc  = r_idx + 1'b1;   // wraps OUT_W-1 -> 0 by width

   assign y          = r_y;
   assign y_valid    = r_valid;
   assign active_idx = r_idx;

   // Next-state and next-output logic; defaults hold every register
   always_comb begin
      w_state_n = r_state;
      w_y_n     = r_y;
      w_valid_n = r_valid;
      w_idx_n   = r_idx;
      w_cnt_n   = r_cnt;
      w_dwell_n = r_dwell;

      case (r_state)
         S_IDLE, S_HOLD: begin
            // stop only matters once something is driven; it beats a command
            if (r_state == S_HOLD && stop) begin
               w_state_n = S_IDLE;
               w_y_n     = C_POL_MASK;
               w_valid_n = 1'b0;
            end else if (w_accept) begin
               w_state_n = mode ? S_SCAN : S_HOLD;
               w_y_n     = (C_ONE << sel) ^ C_POL_MASK;
               w_valid_n = 1'b1;
               w_idx_n   = sel;
               if (mode) begin
                  w_cnt_n   = dwell;
                  w_dwell_n = dwell;
               end
            end
         end
         S_SCAN: begin
            if (stop) begin
               w_state_n = S_IDLE;
               w_y_n     = C_POL_MASK;
               w_valid_n = 1'b0;
            end else if (r_cnt != '0) begin
               w_cnt_n = r_cnt - 1'b1;
            end else begin
               w_idx_n = w_idx_inc;
               w_y_n   = (C_ONE << w_idx_inc) ^ C_POL_MASK;
               w_cnt_n = r_dwell;
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_y_n     = C_POL_MASK;
            w_valid_n = 1'b0;
         end
      endcase
   end

   // State and output registers; reset overrides every input
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_y     <= C_POL_MASK;
         r_valid <= 1'b0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_dwell <= '0;
      end else begin
         r_state <= w_state_n;
         r_y     <= w_y_n;
         r_valid <= w_valid_n;
         r_idx   <= w_idx_n;
         r_cnt   <= w_cnt_n;
         r_dwell <= w_dwell_n;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_decoder_nx_seq.sv
//==============================================================================
// Module   : tb_decoder_nx_seq
// Brief    : Directed self-checking bench for decoder_nx_seq (SEL_W=3).
//            Honours `define ACTIVE_LOW_OUT_EN for expected output polarity.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_decoder_nx_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       mode;
   logic [2:0] sel;
   logic [7:0] dwell;
   logic       stop;
   logic [7:0] y;
   logic       y_valid;
   logic [2:0] active_idx;

   int vectors = 0;
   int errors  = 0;

   decoder_nx_seq #(.SEL_W(3), .DWELL_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mode       (mode),
      .sel        (sel),
      .dwell      (dwell),
      .stop       (stop),
      .y          (y),
      .y_valid    (y_valid),
      .active_idx (active_idx)
   );

   always #5 clk = ~clk;

   // Convert an active-high expectation into the configured output polarity
   function automatic logic [7:0] pol(input logic [7:0] hot);
`ifdef ACTIVE_LOW_OUT_EN
      return ~hot;
`else
      return hot;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle so outputs are sampled away from the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0] scan_seq [7];
      logic [7:0] onehot;
      scan_seq = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0};

      rst = 1'b1; in_valid = 1'b0; mode = 1'b0; sel = '0; dwell = '0; stop = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("reset_y",        32'(y),          32'(pol(8'h00)));
      check("reset_y_valid",  32'(y_valid),    32'd0);
      check("reset_idx",      32'(active_idx), 32'd0);
      check("reset_in_ready", 32'(in_ready),   32'd1);

      // Direct decode, then immediate re-decode without a gap cycle
      in_valid = 1'b1; mode = 1'b0; sel = 3'd5;
      tick();
      check("direct5_y",       32'(y),          32'(pol(8'b0010_0000)));
      check("direct5_y_valid", 32'(y_valid),    32'd1);
      check("direct5_idx",     32'(active_idx), 32'd5);
      check("direct5_ready",   32'(in_ready),   32'd1);
      sel = 3'd2;
      tick();
      check("direct2_y", 32'(y), 32'(pol(8'b0000_0100)));
      in_valid = 1'b0;
      tick();
      check("direct2_hold_y", 32'(y), 32'(pol(8'b0000_0100)));

      // Scan with wrap, entered from HOLD; commands offered during scan are ignored
      in_valid = 1'b1; mode = 1'b1; sel = 3'd6; dwell = 8'd2;
      tick();
      in_valid = 1'b1; mode = 1'b0; sel = 3'd1;
      for (int i = 0; i < 7; i++) begin
         onehot = 8'd1 << scan_seq[i];
         check($sformatf("scan_wrap_idx[%0d]", i),   32'(active_idx), 32'(scan_seq[i]));
         check($sformatf("scan_wrap_y[%0d]", i),     32'(y),          32'(pol(onehot)));
         check($sformatf("scan_wrap_ready[%0d]", i), 32'(in_ready),   32'd0);
         tick();
      end
      in_valid = 1'b0;
      stop = 1'b1;
      tick();
      check("scan_stop_y",       32'(y),          32'(pol(8'h00)));
      check("scan_stop_y_valid", 32'(y_valid),    32'd0);
      check("scan_stop_ready",   32'(in_ready),   32'd1);
      check("scan_stop_idx",     32'(active_idx), 32'd0);

      // Scan with dwell=0 advances every cycle
      stop = 1'b0; in_valid = 1'b1; mode = 1'b1; sel = 3'd0; dwell = 8'd0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         onehot = 8'd1 << (i % 8);
         check($sformatf("scan0_idx[%0d]", i), 32'(active_idx), 32'(i % 8));
         check($sformatf("scan0_y[%0d]", i),   32'(y),          32'(pol(onehot)));
         tick();
      end
      stop = 1'b1;
      tick();
      check("scan0_stop_y_valid", 32'(y_valid),    32'd0);
      check("scan0_stop_idx",     32'(active_idx), 32'd1);

      // Stop together with a command in HOLD: stop wins, command dropped
      stop = 1'b0; in_valid = 1'b1; mode = 1'b0; sel = 3'd4;
      tick();
      check("hold4_y", 32'(y), 32'(pol(8'b0001_0000)));
      stop = 1'b1; sel = 3'd3;
      tick();
      check("hold_stop_y",       32'(y),          32'(pol(8'h00)));
      check("hold_stop_y_valid", 32'(y_valid),    32'd0);
      check("hold_stop_idx",     32'(active_idx), 32'd4);
      stop = 1'b0; in_valid = 1'b0;
      tick();
      check("hold_stop_dropped_y", 32'(y), 32'(pol(8'h00)));

      // stop in IDLE has no effect: the command is still accepted
      stop = 1'b1; in_valid = 1'b1; mode = 1'b0; sel = 3'd7;
      tick();
      check("idle_stop_accept_y",   32'(y),       32'(pol(8'b1000_0000)));
      check("idle_stop_accept_val", 32'(y_valid), 32'd1);
      stop = 1'b0; in_valid = 1'b0;

      // Reset mid-scan has priority over a pending command
      in_valid = 1'b1; mode = 1'b1; sel = 3'd3; dwell = 8'd1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      check("midscan_idx_before_rst", 32'(active_idx), 32'd4);
      rst = 1'b1; in_valid = 1'b1; mode = 1'b0; sel = 3'd6;
      tick();
      check("rst_midscan_y",       32'(y),          32'(pol(8'h00)));
      check("rst_midscan_y_valid", 32'(y_valid),    32'd0);
      check("rst_midscan_idx",     32'(active_idx), 32'd0);
      check("rst_midscan_ready",   32'(in_ready),   32'd1);

      // Direct decode of index 1 after reset release
      rst = 1'b0; in_valid = 1'b1; mode = 1'b0; sel = 3'd1;
      tick();
      check("direct1_y", 32'(y), 32'(pol(8'b0000_0010)));
      in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire
